sample_iterator: RTL and testbench

SAMPLE_ITERATOR -- requirements
Module: sample_iterator

---
 rtl/sample_iterator_pkg.sv | 24 ++
 rtl/sample_iterator_iter_next_samp.sv | 34 +++
 rtl/sample_iterator.sv | 118 +++++++++++
 tb/tb_sample_iterator.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_iterator_pkg.sv
// rtl/sample_iterator_pkg.sv - shared rasterizer definitions: iterator FSM states and sub-sample step lookup
package sample_iterator_pkg;

   typedef logic [0:0] iter_state_t;

   localparam iter_state_t ST_WAIT = 1'b0;
   localparam iter_state_t ST_TEST = 1'b1;

   // One-hot select, highest set bit wins; an all-zero select falls back to one pixel.
   function automatic logic [31:0] step_of(input logic [3:0] sub, input int radix);
      logic [31:0] one;
      one = 32'd1;
      if (sub[3])      step_of = one << radix;
      else if (sub[2]) step_of = one << (radix - 1);
      else if (sub[1]) step_of = one << (radix - 2);
      else if (sub[0]) step_of = one << (radix - 3);
      else             step_of = one << radix;
   endfunction

   function automatic logic [31:0] grid_mask(input logic [3:0] sub, input int radix);
      grid_mask = ~(step_of(sub, radix) - 32'd1);
   endfunction

endpackage

// File: rtl/sample_iterator_iter_next_samp.sv
// rtl/sample_iterator_iter_next_samp.sv - raster next-sample position and last-sample detection
module iter_next_samp
   import sample_iterator_pkg::*;
#(
   parameter int SIGFIG = 24
) (
   input  logic signed [SIGFIG-1:0] samp_x,
   input  logic signed [SIGFIG-1:0] samp_y,
   input  logic signed [SIGFIG-1:0] ll_x,
   input  logic signed [SIGFIG-1:0] ur_x,
   input  logic signed [SIGFIG-1:0] ur_y,
   input  logic        [SIGFIG-1:0] step,
   output logic signed [SIGFIG-1:0] next_x,
   output logic signed [SIGFIG-1:0] next_y,
   output logic                     last
);

   // One extra bit so x+step just past the positive limit still compares greater than ur.
   logic signed [SIGFIG:0] x_inc;
   logic signed [SIGFIG:0] y_inc;
   logic                   x_wrap;
   logic                   y_wrap;

   always_comb begin
      x_inc  = $signed({samp_x[SIGFIG-1], samp_x}) + $signed({1'b0, step});
      y_inc  = $signed({samp_y[SIGFIG-1], samp_y}) + $signed({1'b0, step});
      x_wrap = x_inc > $signed({ur_x[SIGFIG-1], ur_x});
      y_wrap = y_inc > $signed({ur_y[SIGFIG-1], ur_y});
      next_x = x_wrap ? ll_x : x_inc[SIGFIG-1:0];
      next_y = x_wrap ? y_inc[SIGFIG-1:0] : samp_y;
      last   = x_wrap && y_wrap;
   end

endmodule

// File: rtl/sample_iterator.sv
// rtl/sample_iterator.sv - walks a triangle's bounding box on the sub-sample grid, one sample per cycle
module sample_iterator
   import sample_iterator_pkg::*;
#(
   parameter int SIGFIG = 24,
   parameter int RADIX  = 10,
   parameter int VERTS  = 3,
   parameter int AXIS   = 3,
   parameter int COLORS = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [SIGFIG-1:0] tri_R15S [VERTS][AXIS],
   input  logic        [SIGFIG-1:0] color_R15U [COLORS],
   input  logic signed [SIGFIG-1:0] box_R15S [2][2],
   input  logic                     validTri_R15H,
   input  logic        [3:0]        subSample_RnnU,
   output logic                     halt_R15L,
   output logic signed [SIGFIG-1:0] tri_R16S [VERTS][AXIS],
   output logic        [SIGFIG-1:0] color_R16U [COLORS],
   output logic signed [SIGFIG-1:0] sample_R16S [2],
   output logic                     validSamp_R16H
);

   iter_state_t              state_q;
   logic signed [SIGFIG-1:0] ll_x_q;
   logic signed [SIGFIG-1:0] ur_x_q;
   logic signed [SIGFIG-1:0] ur_y_q;

   logic        [SIGFIG-1:0] step;
   logic        [SIGFIG-1:0] mask;
   logic signed [SIGFIG-1:0] snap_ll_x;
   logic signed [SIGFIG-1:0] snap_ll_y;
   logic signed [SIGFIG-1:0] snap_ur_x;
   logic signed [SIGFIG-1:0] snap_ur_y;
   logic                     inverted;
   logic                     single;
   logic                     accept;

   logic signed [SIGFIG-1:0] next_x;
   logic signed [SIGFIG-1:0] next_y;
   logic                     last;

   always_comb begin
      step      = SIGFIG'(step_of(subSample_RnnU, RADIX));
      mask      = SIGFIG'(grid_mask(subSample_RnnU, RADIX));
      snap_ll_x = $signed(box_R15S[0][0] & mask);
      snap_ll_y = $signed(box_R15S[0][1] & mask);
      snap_ur_x = $signed(box_R15S[1][0] & mask);
      snap_ur_y = $signed(box_R15S[1][1] & mask);
      inverted  = (snap_ur_x < snap_ll_x) || (snap_ur_y < snap_ll_y);
      single    = (snap_ur_x == snap_ll_x) && (snap_ur_y == snap_ll_y);
   end

   iter_next_samp #(
      .SIGFIG (SIGFIG)
   ) u_next_samp (
      .samp_x (sample_R16S[0]),
      .samp_y (sample_R16S[1]),
      .ll_x   (ll_x_q),
      .ur_x   (ur_x_q),
      .ur_y   (ur_y_q),
      .step   (step),
      .next_x (next_x),
      .next_y (next_y),
      .last   (last)
   );

   assign halt_R15L = (state_q == ST_WAIT) || last;
   assign accept    = validTri_R15H && halt_R15L;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_WAIT;
         validSamp_R16H <= 1'b0;
         ll_x_q         <= '0;
         ur_x_q         <= '0;
         ur_y_q         <= '0;
         sample_R16S[0] <= '0;
         sample_R16S[1] <= '0;
         for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
               tri_R16S[v][a] <= '0;
         for (int c = 0; c < COLORS; c++)
            color_R16U[c] <= '0;
      end else if (accept) begin
         ll_x_q <= snap_ll_x;
         ur_x_q <= snap_ur_x;
         ur_y_q <= snap_ur_y;
         for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
               tri_R16S[v][a] <= tri_R15S[v][a];
         for (int c = 0; c < COLORS; c++)
            color_R16U[c] <= color_R15U[c];
         if (inverted) begin
            state_q        <= ST_WAIT;
            validSamp_R16H <= 1'b0;
         end else begin
            // A one-sample box never needs TEST: its only sample is also its last.
            state_q        <= single ? ST_WAIT : ST_TEST;
            validSamp_R16H <= 1'b1;
            sample_R16S[0] <= snap_ll_x;
            sample_R16S[1] <= snap_ll_y;
         end
      end else if (state_q == ST_TEST) begin
         if (last) begin
            state_q        <= ST_WAIT;
            validSamp_R16H <= 1'b0;
         end else begin
            sample_R16S[0] <= next_x;
            sample_R16S[1] <= next_y;
         end
      end else begin
         validSamp_R16H <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sample_iterator.sv
// tb/tb_sample_iterator.sv - randomized self-checking bench for sample_iterator
module tb_sample_iterator;

   localparam int SIGFIG = 24;
   localparam int RADIX  = 10;
   localparam int VERTS  = 3;
   localparam int AXIS   = 3;
   localparam int COLORS = 3;
   localparam int MAXT   = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic signed [SIGFIG-1:0] tri_in   [VERTS][AXIS];
   logic        [SIGFIG-1:0] col_in   [COLORS];
   logic signed [SIGFIG-1:0] box_in   [2][2];
   logic                     valid_tri = 1'b0;
   logic        [3:0]        sub = 4'b1000;
   logic                     halt;
   logic signed [SIGFIG-1:0] tri_out  [VERTS][AXIS];
   logic        [SIGFIG-1:0] col_out  [COLORS];
   logic signed [SIGFIG-1:0] samp     [2];
   logic                     vsamp;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int x;
      int y;
      int id;
   } exp_t;

   exp_t q[$];
   int   n_tri;
   int   t_llx [MAXT];
   int   t_lly [MAXT];
   int   t_urx [MAXT];
   int   t_ury [MAXT];
   logic [SIGFIG-1:0] t_tri [MAXT][VERTS][AXIS];
   logic [SIGFIG-1:0] t_col [MAXT][COLORS];

   sample_iterator #(
      .SIGFIG (SIGFIG),
      .RADIX  (RADIX),
      .VERTS  (VERTS),
      .AXIS   (AXIS),
      .COLORS (COLORS)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .tri_R15S       (tri_in),
      .color_R15U     (col_in),
      .box_R15S       (box_in),
      .validTri_R15H  (valid_tri),
      .subSample_RnnU (sub),
      .halt_R15L      (halt),
      .tri_R16S       (tri_out),
      .color_R16U     (col_out),
      .sample_R16S    (samp),
      .validSamp_R16H (vsamp)
   );

   function automatic int step_size(input logic [3:0] s);
      if (s[3])      return 1024;
      else if (s[2]) return 512;
      else if (s[1]) return 256;
      else           return 128;
   endfunction

   function automatic int snap(input int v, input int s);
      int m;
      m = v % s;
      if (m < 0) m += s;
      return v - m;
   endfunction

   task automatic clear_inputs();
      for (int v = 0; v < VERTS; v++)
         for (int a = 0; a < AXIS; a++)
            tri_in[v][a] = '0;
      for (int c = 0; c < COLORS; c++)
         col_in[c] = '0;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++)
            box_in[i][j] = '0;
   endtask

   task automatic add_tri(input int llx, input int lly, input int urx, input int ury);
      t_llx[n_tri] = llx;
      t_lly[n_tri] = lly;
      t_urx[n_tri] = urx;
      t_ury[n_tri] = ury;
      for (int v = 0; v < VERTS; v++)
         for (int a = 0; a < AXIS; a++)
            t_tri[n_tri][v][a] = SIGFIG'($urandom);
      for (int c = 0; c < COLORS; c++)
         t_col[n_tri][c] = SIGFIG'($urandom);
      n_tri++;
   endtask

   task automatic load_tri(input int k);
      for (int v = 0; v < VERTS; v++)
         for (int a = 0; a < AXIS; a++)
            tri_in[v][a] = t_tri[k][v][a];
      for (int c = 0; c < COLORS; c++)
         col_in[c] = t_col[k][c];
      box_in[0][0] = t_llx[k][SIGFIG-1:0];
      box_in[0][1] = t_lly[k][SIGFIG-1:0];
      box_in[1][0] = t_urx[k][SIGFIG-1:0];
      box_in[1][1] = t_ury[k][SIGFIG-1:0];
   endtask

   // Reference: every grid point of the snapped box, rows bottom to top, left to right.
   task automatic push_exp(input int id, input int s);
      exp_t e;
      int   llx, lly, urx, ury;
      llx = snap(t_llx[id], s);
      lly = snap(t_lly[id], s);
      urx = snap(t_urx[id], s);
      ury = snap(t_ury[id], s);
      for (int y = lly; y <= ury; y += s)
         for (int x = llx; x <= urx; x += s) begin
            e.x  = x;
            e.y  = y;
            e.id = id;
            q.push_back(e);
         end
   endtask

   task automatic run_seq(input string name, input logic [3:0] s);
      int   k;
      int   cyc;
      bit   bad;
      exp_t e;
      k   = 0;
      cyc = 0;
      sub = s;
      q.delete();
      while ((k < n_tri || q.size() > 0) && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         if (vsamp) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL %s unexpected_sample got=(%0d,%0d) expected no sample", name, samp[0], samp[1]);
            end else begin
               e = q.pop_front();
               if (samp[0] !== e.x[SIGFIG-1:0] || samp[1] !== e.y[SIGFIG-1:0]) begin
                  errors++;
                  $display("FAIL %s sample got=(%0d,%0d) expected=(%0d,%0d)", name, samp[0], samp[1], e.x, e.y);
               end
               bad = 1'b0;
               for (int v = 0; v < VERTS; v++)
                  for (int a = 0; a < AXIS; a++)
                     if (tri_out[v][a] !== t_tri[e.id][v][a]) bad = 1'b1;
               for (int c = 0; c < COLORS; c++)
                  if (col_out[c] !== t_col[e.id][c]) bad = 1'b1;
               checks++;
               if (bad) begin
                  errors++;
                  $display("FAIL %s tri_color got=%0h/%0h expected=%0h/%0h", name,
                           tri_out[0][0], col_out[0], t_tri[e.id][0][0], t_col[e.id][0]);
               end
            end
         end else if (q.size() > 0) begin
            checks++;
            errors++;
            e = q.pop_front();
            $display("FAIL %s bubble got=valid 0 expected=sample (%0d,%0d)", name, e.x, e.y);
         end
         checks++;
         if (halt !== (q.size() == 0)) begin
            errors++;
            $display("FAIL %s halt got=%0b expected=%0b", name, halt, (q.size() == 0));
         end
         if (k < n_tri) begin
            load_tri(k);
            valid_tri = 1'b1;
            if (halt) begin
               push_exp(k, step_size(s));
               k++;
            end
         end else begin
            valid_tri = 1'b0;
         end
      end
      valid_tri = 1'b0;
      checks++;
      if (cyc >= 5000) begin
         errors++;
         $display("FAIL %s timeout got=%0d pending expected=0", name, q.size());
      end
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (vsamp !== 1'b0 || halt !== 1'b1) begin
            errors++;
            $display("FAIL %s idle got=valid %0b halt %0b expected=valid 0 halt 1", name, vsamp, halt);
         end
      end
   endtask

   task automatic check_zero(input string name);
      bit bad;
      bad = 1'b0;
      for (int v = 0; v < VERTS; v++)
         for (int a = 0; a < AXIS; a++)
            if (tri_out[v][a] !== '0) bad = 1'b1;
      for (int c = 0; c < COLORS; c++)
         if (col_out[c] !== '0) bad = 1'b1;
      if (samp[0] !== '0 || samp[1] !== '0) bad = 1'b1;
      checks++;
      if (vsamp !== 1'b0 || halt !== 1'b1 || bad) begin
         errors++;
         $display("FAIL %s got=valid %0b halt %0b nonzero %0b expected=valid 0 halt 1 nonzero 0",
                  name, vsamp, halt, bad);
      end
   endtask

   task automatic test_reset();
      clear_inputs();
      @(negedge clk);
      check_zero("reset_state");
      rst = 1'b1;
      @(negedge clk);
      check_zero("after_release");
   endtask

   task automatic test_single();
      n_tri = 0;
      add_tri(1024, 2048, 1024, 2048);
      run_seq("single_sample", 4'b1000);
   endtask

   task automatic test_half_step();
      n_tri = 0;
      add_tri(0, 0, 1024, 1024);
      run_seq("half_step", 4'b0100);
   endtask

   task automatic test_snap();
      n_tri = 0;
      add_tri(1300, 700, 2100, 1100);
      run_seq("snap_box", 4'b1000);
   endtask

   task automatic test_inverted();
      n_tri = 0;
      add_tri(2048, 0, 1024, 0);
      run_seq("inverted_box", 4'b1000);
   endtask

   task automatic test_back_to_back();
      n_tri = 0;
      add_tri(0, 0, 1024, 1024);
      add_tri(-600, 300, 700, 900);
      add_tri(2048, 2048, 2048, 2048);
      add_tri(5000, 5000, 6000, 5000);
      run_seq("back_to_back", 4'b0100);
   endtask

   task automatic test_limits();
      n_tri = 0;
      add_tri(8388607 - 3000, 0, 8388607, 1024);
      add_tri(-3000, -2500, -100, -1);
      add_tri(0, 8388607 - 1500, 300, 8388607);
      run_seq("limits", 4'b0010);
   endtask

   task automatic test_random();
      int s, llx, lly;
      for (int r = 0; r < 8; r++) begin
         n_tri = 0;
         s = step_size(4'b0001 << (r % 4));
         for (int t = 0; t < 4; t++) begin
            llx = int'($urandom_range(0, 200000)) - 100000;
            lly = int'($urandom_range(0, 200000)) - 100000;
            if ($urandom_range(0, 7) == 0)
               add_tri(llx, lly, llx - int'($urandom_range(s, 4 * s)), lly + int'($urandom_range(0, 3 * s)));
            else
               add_tri(llx, lly, llx + int'($urandom_range(0, 5 * s)), lly + int'($urandom_range(0, 5 * s)));
         end
         run_seq("random", 4'b0001 << (r % 4));
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      int cyc;
      n_tri = 0;
      add_tri(0, 0, 1024, 1024);
      sub = 4'b0100;
      @(negedge clk);
      load_tri(0);
      valid_tri = 1'b1;
      seen = 0;
      cyc  = 0;
      while (seen < 3 && cyc < 20) begin
         @(negedge clk);
         valid_tri = 1'b0;
         cyc++;
         if (vsamp) seen++;
      end
      checks++;
      if (seen != 3) begin
         errors++;
         $display("FAIL reset_mid_reach got=%0d samples expected=3", seen);
      end
      rst = 1'b0;
      #1;
      check_zero("reset_mid_async");
      @(negedge clk);
      rst = 1'b1;
      repeat (12) begin
         @(negedge clk);
         checks++;
         if (vsamp !== 1'b0 || halt !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_residual got=valid %0b halt %0b expected=valid 0 halt 1", vsamp, halt);
         end
      end
   endtask

   initial begin
      n_tri = 0;
      test_reset();
      test_single();
      test_half_step();
      test_snap();
      test_inverted();
      test_back_to_back();
      test_limits();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
